sync_tx_sched: RTL and testbench



---
 rtl/sync_tx_sched.sv | 78 +++++++
 tb/tb_sync_tx_sched.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/sync_tx_sched.sv
// sync_tx_sched: round-robin scheduler feeding one CDC word-sync channel, holding each {toggle,id,data} word for HOLD_CYCLES
//   clk, rst_n        source clock, async active-low reset
//   en                arbitration enable (blocks new grants only)
//   req, req_data     per-requester level request and packed payloads
//   gnt               one-hot grant pulse, coincident with sync_r
//   sync_r, sync_word channel load strobe and channel input word
//   busy              high while the loaded word is being held
module sync_tx_sched #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 16,
  parameter int ID_WIDTH    = 2,
  parameter int HOLD_CYCLES = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          sync_r,
  output logic [DATA_WIDTH+ID_WIDTH:0]  sync_word,
  output logic                          busy
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int WW = DATA_WIDTH + ID_WIDTH + 1;
  typedef enum logic {IDLE, HOLD} state_t;
  state_t               r_state, w_state;
  logic [7:0]           r_cnt, w_cnt;
  logic [PW-1:0]        r_ptr, w_ptr, w_win;
  logic                 r_tog, w_tog, r_sync, w_sync, w_found, w_go;
  logic [NUM_REQ-1:0]   r_gnt, w_gnt;
  logic [WW-1:0]        r_word, w_word;
  // scan offsets from farthest to nearest so the nearest asserted request after r_ptr wins
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req[PW'((int'(r_ptr) + k) % NUM_REQ)]) begin
        w_found = 1'b1;
        w_win   = PW'((int'(r_ptr) + k) % NUM_REQ);
      end
    end
  end
  // the strobe cycle is spent in IDLE with arbitration suppressed; the counted hold starts after it
  always_comb begin
    w_go    = (r_state == IDLE) && !r_sync && en && w_found;
    w_state = r_sync ? HOLD : (r_state == HOLD && r_cnt == 8'd1) ? IDLE : r_state;
    w_cnt   = r_sync ? 8'(HOLD_CYCLES) : (r_state == HOLD) ? r_cnt - 8'd1 : r_cnt;
    w_gnt   = w_go ? NUM_REQ'(1) << w_win : '0;
    w_sync  = w_go;
    w_tog   = r_tog ^ w_go;
    w_ptr   = w_go ? w_win : r_ptr;
    w_word  = w_go ? {~r_tog, ID_WIDTH'(w_win), req_data[w_win*DATA_WIDTH +: DATA_WIDTH]} : r_word;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_ptr   <= PW'(NUM_REQ - 1);
      r_tog   <= 1'b0;
      r_sync  <= 1'b0;
      r_gnt   <= '0;
      r_word  <= '0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_ptr   <= w_ptr;
      r_tog   <= w_tog;
      r_sync  <= w_sync;
      r_gnt   <= w_gnt;
      r_word  <= w_word;
    end
  end
  assign gnt       = r_gnt;
  assign sync_r    = r_sync;
  assign sync_word = r_word;
  assign busy      = (r_state == HOLD);
endmodule

// File: tb/tb_sync_tx_sched.sv
// tb_sync_tx_sched: directed and random checks of sync_tx_sched against a timing-rule reference model
module tb_sync_tx_sched;
  localparam int N = 4, DW = 16, IW = 2, H = 8, W = DW + IW + 1;
  logic clk = 0, rst_n = 0, en = 0;
  logic [N-1:0] req = '0, keep = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0] gnt;
  logic sync_r, busy;
  logic [W-1:0] sync_word;
  int total = 0, bad = 0, cyc = 0, last_s = -100, m_ptr = N - 1, bcnt = 0;
  logic m_tog = 0;
  logic [W-1:0] m_word = '0;
  bit autod = 0;
  int gq[$], sq[$];
  logic [W-1:0] wq[$];
  always #5 clk = ~clk;
  sync_tx_sched #(.NUM_REQ(N), .DATA_WIDTH(DW), .ID_WIDTH(IW), .HOLD_CYCLES(H)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .req_data(req_data),
    .gnt(gnt), .sync_r(sync_r), .sync_word(sync_word), .busy(busy));
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  task automatic mreset();
    m_ptr = N - 1; m_tog = 0; m_word = '0; last_s = -100;
  endtask
  task automatic tick();
    logic [N-1:0] e_gnt;
    logic e_sync, e_busy;
    int w;
    e_gnt = '0; e_sync = 0; w = -1;
    if (!rst_n) mreset();
    else if (en && |req && cyc >= last_s + H + 1) begin
      for (int k = 1; k <= N; k++) if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      m_tog = ~m_tog; m_ptr = w; e_gnt = N'(1) << w; e_sync = 1;
      m_word = {m_tog, IW'(w), req_data[w*DW +: DW]};
      last_s = cyc + 1;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    e_busy = rst_n && cyc >= last_s + 1 && cyc <= last_s + H;
    chk("gnt", 32'(gnt), 32'(e_gnt));
    chk("sync_r", 32'(sync_r), 32'(e_sync));
    chk("sync_word", 32'(sync_word), 32'(m_word));
    chk("busy", 32'(busy), 32'(e_busy));
    if (busy) bcnt++;
    for (int k = 0; k < N; k++) if (gnt[k]) begin gq.push_back(k); sq.push_back(cyc); wq.push_back(sync_word); end
    if (autod) req = keep & ~gnt;
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic do_reset();
    rst_n = 0;
    #1;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_sync_r", 32'(sync_r), 0);
    chk("rst_word", 32'(sync_word), 0);
    chk("rst_busy", 32'(busy), 0);
    mreset();
    tick();
    rst_n = 1;
    gq.delete(); sq.delete(); wq.delete(); bcnt = 0;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    do_reset();
    en = 1;
    // single transfer of an all-zero payload from requester 0
    autod = 1; keep = '0; req = 4'b0001; req_data = '0;
    run(14);
    chk("t1_ngrants", gq.size(), 1);
    chk("t1_word", 32'(wq[0]), 32'h40000);
    chk("t1_busy_cycles", bcnt, H);
    // identical payload twice still flips the toggle
    do_reset();
    req_data[15:0] = 16'hA5A5; keep = 4'b0001; req = 4'b0001;
    run(12);
    keep = '0; req = '0;
    run(2);
    chk("t2_ngrants", gq.size(), 2);
    chk("t2_spacing", sq[1] - sq[0], H + 2);
    chk("t2_word0", 32'(wq[0]), 32'h4A5A5);
    chk("t2_word1", 32'(wq[1]), 32'h0A5A5);
    // all requesters active: round-robin order and minimum spacing
    do_reset();
    for (int k = 0; k < N; k++) req_data[k*DW +: DW] = 16'(16'h1000 + k);
    keep = 4'b1111; req = 4'b1111;
    run(45);
    chk("t3_ngrants", gq.size(), 5);
    for (int i = 0; i < 5; i++) chk("t3_order", gq[i], i % N);
    for (int i = 1; i < 5; i++) chk("t3_spacing", sq[i] - sq[i-1], H + 2);
    chk("t3_word3", 32'(wq[3]), {13'd0, 1'b0, 2'd3, 16'h1003});
    // request mid-hold with en low: no grant until en returns
    do_reset();
    keep = 4'b0010; req = 4'b0010;
    run(3);
    keep = 4'b0100; req = 4'b0100; en = 0;
    for (int i = 0; i < 40 && busy; i++) tick();
    chk("t4_idle", 32'(busy), 0);
    run(3);
    chk("t4_no_grant", gq.size(), 1);
    en = 1;
    tick();
    chk("t4_gnt", 32'(gnt), 4'b0100);
    chk("t4_id", 32'(sync_word[DW +: IW]), 2);
    keep = '0; req = '0;
    run(12);
    // async reset with four hold cycles left
    do_reset();
    keep = 4'b0010; req = 4'b0010;
    run(6);
    keep = 4'b1111; req = 4'b1111;
    do_reset();
    chk("t5_first_gnt", gq.size(), 0);
    tick();
    chk("t5_gnt", 32'(gnt), 4'b0001);
    chk("t5_toggle", 32'(sync_word[W-1]), 1);
    // requester 0 never drops; requester 2 joins later
    do_reset();
    autod = 0; req = 4'b0001;
    run(31);
    chk("t6_ngrants", gq.size(), 4);
    for (int i = 1; i < 4; i++) chk("t6_spacing", sq[i] - sq[i-1], H + 2);
    req = 4'b0101;
    run(40);
    chk("t6_ngrants2", gq.size(), 8);
    for (int i = 4; i < 8; i++) chk("t6_order", gq[i], (i % 2 == 0) ? 2 : 0);
    // random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      en = $urandom_range(0, 3) != 0;
      req = N'($urandom);
      req_data = {$urandom, $urandom};
      if ($urandom_range(0, 99) == 0) do_reset();
      else tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
